// File: rtl/dm_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dm_bus_arbiter_pkg
//  Description : Shared constants for the DM bus arbiter. Holds the region
//                address map, the region one-hot bit positions and the
//                sequencer state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package dm_bus_arbiter_pkg;

    // Region address map (inclusive bounds, full 32-bit compare)
    localparam logic [31:0] c_DM_BASE  = 32'h0000_0000;
    localparam logic [31:0] c_DM_END   = 32'h0000_2fff;
    localparam logic [31:0] c_TC0_BASE = 32'h0000_7f00;
    localparam logic [31:0] c_TC0_END  = 32'h0000_7f0b;
    localparam logic [31:0] c_TC1_BASE = 32'h0000_7f10;
    localparam logic [31:0] c_TC1_END  = 32'h0000_7f1b;
    localparam logic [31:0] c_PR_BASE  = 32'h0000_7f20;
    localparam logic [31:0] c_PR_END   = 32'h0000_7f23;

    // Bit positions in the one-hot region vector
    localparam int c_RGN_DM  = 0;
    localparam int c_RGN_TC0 = 1;
    localparam int c_RGN_TC1 = 2;
    localparam int c_RGN_PR  = 3;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Inclusive range test used by the region decoder
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_region_decode.sv
`default_nettype none
// ============================================================================
//  Module      : dm_region_decode
//  Description : Maps a byte address to a one-hot region vector
//                {Pr, TC1, TC0, DM} and flags addresses that hit no region.
//  Revision    : 1.0  initial release
// ============================================================================
module dm_region_decode
    import dm_bus_arbiter_pkg::*;
(
    input  logic [31:0] i_addr,
    output logic [3:0]  o_region,
    output logic        o_unmapped
);

    logic [3:0] w_region;

    // Each region bit is an independent full-width range compare
    always_comb begin
        w_region            = '0;
        w_region[c_RGN_DM]  = in_range(i_addr, c_DM_BASE,  c_DM_END);
        w_region[c_RGN_TC0] = in_range(i_addr, c_TC0_BASE, c_TC0_END);
        w_region[c_RGN_TC1] = in_range(i_addr, c_TC1_BASE, c_TC1_END);
        w_region[c_RGN_PR]  = in_range(i_addr, c_PR_BASE,  c_PR_END);
    end

    assign o_region   = w_region;
    assign o_unmapped = ~|w_region;

endmodule
`default_nettype wire

// File: rtl/dm_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dm_bus_arbiter
//  Description : Two-master round-robin arbiter and sequencer for the shared
//                data bus. One transaction in flight at a time, per-region
//                wait states, registered read data, unmapped-address errors.
//  Revision    : 1.0  initial release
// ============================================================================
module dm_bus_arbiter
    import dm_bus_arbiter_pkg::*;
#(
    parameter int unsigned DM_WAIT = 1,
    parameter int unsigned IO_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_we,
    input  logic [3:0]  m0_byteen,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_we,
    input  logic [3:0]  m1_byteen,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_byteen,
    input  logic [31:0] bus_rdata
);

    localparam logic [2:0] c_DM_WAIT = 3'(DM_WAIT);
    localparam logic [2:0] c_IO_WAIT = 3'(IO_WAIT);

    state_t      r_state;
    logic        r_last_grant;   // 1 = m1 was granted last, so m0 wins a tie
    logic        r_master;
    logic [31:0] r_addr;
    logic        r_we;
    logic [3:0]  r_byteen;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [2:0]  r_wait;
    logic [31:0] r_rdata;

    logic        w_idle;
    logic        w_access;
    logic        w_last_access;
    logic        w_resp;
    logic        w_any_req;
    logic        w_pick_m1;
    logic [31:0] w_sel_addr;
    logic        w_sel_we;
    logic [3:0]  w_sel_byteen;
    logic [31:0] w_sel_wdata;
    logic [3:0]  w_region;
    logic        w_unmapped;
    logic [2:0]  w_region_wait;

    assign w_idle        = (r_state == ST_IDLE);
    assign w_access      = (r_state == ST_ACCESS);
    assign w_resp        = (r_state == ST_RESP);
    assign w_last_access = w_access && (r_wait == 3'd0);
    assign w_any_req     = m0_req | m1_req;

    // m1 wins when it is the only requester, or on a tie when m0 went last
    assign w_pick_m1 = m1_req & (~m0_req | ~r_last_grant);

    assign m0_gnt = w_idle & m0_req & ~w_pick_m1;
    assign m1_gnt = w_idle & w_pick_m1;

    assign w_sel_addr   = w_pick_m1 ? m1_addr   : m0_addr;
    assign w_sel_we     = w_pick_m1 ? m1_we     : m0_we;
    assign w_sel_byteen = w_pick_m1 ? m1_byteen : m0_byteen;
    assign w_sel_wdata  = w_pick_m1 ? m1_wdata  : m0_wdata;

    dm_region_decode u_decode (
        .i_addr     (w_sel_addr),
        .o_region   (w_region),
        .o_unmapped (w_unmapped)
    );

    assign w_region_wait = w_region[c_RGN_DM] ? c_DM_WAIT :
                           (|w_region[c_RGN_PR:c_RGN_TC0]) ? c_IO_WAIT : 3'd0;

    // Sequencer: grant and latch in IDLE, count waits in ACCESS, respond in RESP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_master     <= 1'b0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_byteen     <= '0;
            r_wdata      <= '0;
            r_err        <= 1'b0;
            r_wait       <= '0;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_master     <= w_pick_m1;
                        r_last_grant <= w_pick_m1;
                        r_addr       <= w_sel_addr;
                        r_we         <= w_sel_we;
                        r_byteen     <= w_sel_byteen;
                        r_wdata      <= w_sel_wdata;
                        r_err        <= w_unmapped;
                        r_wait       <= w_unmapped ? 3'd0 : w_region_wait;
                        r_state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_wait == 3'd0) begin
                        r_rdata <= (r_we | r_err) ? 32'd0 : bus_rdata;
                        r_state <= ST_RESP;
                    end else begin
                        r_wait <= r_wait - 3'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus is driven only while a transaction is in ACCESS; strobe on the final cycle
    assign bus_addr   = w_access ? r_addr  : 32'd0;
    assign bus_wdata  = w_access ? r_wdata : 32'd0;
    assign bus_byteen = (w_last_access && r_we && !r_err) ? r_byteen : 4'd0;

    // Response steered to the master that owns the transaction
    assign m0_rvalid = w_resp & ~r_master;
    assign m1_rvalid = w_resp &  r_master;
    assign m0_rdata  = m0_rvalid ? r_rdata : 32'd0;
    assign m1_rdata  = m1_rvalid ? r_rdata : 32'd0;
    assign m0_err    = m0_rvalid & r_err;
    assign m1_err    = m1_rvalid & r_err;

endmodule
`default_nettype wire
